// File: rtl/adc_capture.sv
// ADC capture front end: generates the ADC sample clock, decimates samples and
// stores them in a circular buffer around a level/edge or forced trigger.
//
// state | meaning
// IDLE  | waiting for arm
// PRE   | filling the pre-trigger history
// ARMED | writing samples and watching for a trigger
// POST  | writing the remainder of the buffer after the trigger
// DONE  | buffer complete, read-out only; arm restarts
module adc_capture #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int PRE_TRIG = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic              ad_clk,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_otr,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [7:0]        decim,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_pos,
  output logic              otr_flag,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PRE_LD  = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_LD = ADDR_W'(DEPTH - PRE_TRIG - 1);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] s_q, prev;
  logic              otr_q, keep_q, have_prev, force_seen;
  logic [7:0]        dcnt;
  logic [ADDR_W-1:0] wptr, cnt;
  logic              arm_ok, we, lvl_hit, trig_hit;

  always_comb begin
    arm_ok   = arm && (state == IDLE || state == DONE);
    we       = keep_q && (state == PRE || state == ARMED || state == POST);
    lvl_hit  = have_prev && (trig_edge ? (prev >= trig_level && trig_level > s_q)
                                       : (prev < trig_level && trig_level <= s_q));
    trig_hit = (state == ARMED) && keep_q && (force_seen || force_trig || lvl_hit);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (arm) state_nxt = (PRE_TRIG == 0) ? ARMED : PRE;
      PRE:        if (keep_q && cnt == ONE) state_nxt = ARMED;
      ARMED:      if (trig_hit) state_nxt = (POST_LD == '0) ? DONE : POST;
      POST:       if (keep_q && cnt == ONE) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // sample path: the edge where ad_clk is high is the ADC sample event
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ad_clk <= 1'b0;
      s_q    <= '0;
      otr_q  <= 1'b0;
      dcnt   <= '0;
      keep_q <= 1'b0;
    end else begin
      ad_clk <= ~ad_clk;
      if (ad_clk) begin
        s_q   <= ad_data;
        otr_q <= ad_otr;
      end
      // a sample registered on the arm edge belongs to the old capture
      keep_q <= ad_clk && (dcnt == 8'd0) && !arm_ok;
      if (arm_ok)      dcnt <= '0;
      else if (ad_clk) dcnt <= (dcnt >= decim) ? 8'd0 : dcnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr       <= '0;
      cnt        <= '0;
      prev       <= '0;
      have_prev  <= 1'b0;
      force_seen <= 1'b0;
      trig_pos   <= '0;
      otr_flag   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy       <= (state_nxt == PRE || state_nxt == ARMED || state_nxt == POST);
      done       <= (state_nxt == DONE);
      force_seen <= (state == ARMED) && (state_nxt == ARMED) && (force_seen || force_trig);
      if (arm_ok) begin
        wptr      <= '0;
        cnt       <= PRE_LD;
        have_prev <= 1'b0;
        otr_flag  <= 1'b0;
      end else begin
        if (we) begin
          wptr      <= wptr + ONE;
          prev      <= s_q;
          have_prev <= 1'b1;
          if (otr_q) otr_flag <= 1'b1;
        end
        if (trig_hit) begin
          trig_pos <= wptr;
          cnt      <= POST_LD;
        end else if (keep_q && (state == PRE || state == POST)) begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (we) mem[wptr] <= s_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rd_data <= '0;
    else            rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: drives synthetic ADC waveforms and checks
// trigger position, completion timing, flags and buffer contents via a read queue.
module tb_adc_capture;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       ad_clk;
  logic [7:0] ad_data;
  logic       ad_otr;
  logic       arm;
  logic       force_trig;
  logic [7:0] trig_level;
  logic       trig_edge;
  logic [7:0] decim;
  logic       busy, done, otr_flag;
  logic [7:0] trig_pos;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  int n_vec = 0;
  int n_err = 0;
  int idx = 0;
  int mode = 0;
  int otr_idx = -1;
  int ftk;
  logic [7:0] rdq[$];

  adc_capture #(.DATA_W(8), .ADDR_W(8), .PRE_TRIG(32)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_clk(ad_clk),
    .ad_data(ad_data), .ad_otr(ad_otr), .arm(arm), .force_trig(force_trig),
    .trig_level(trig_level), .trig_edge(trig_edge), .decim(decim),
    .busy(busy), .done(done), .trig_pos(trig_pos), .otr_flag(otr_flag),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int k);
    case (mode)
      1:       return 8'(255 - k);
      2:       return 8'd50;
      default: return 8'(k);
    endcase
  endfunction

  // value every buffer address must hold at the end of each capture
  function automatic logic [7:0] exp_val(input int tst, input int a);
    case (tst)
      1:       return 8'(a);
      2:       return 8'(255 - a);
      3:       return 8'd50;
      default: return 8'(4 * a);
    endcase
  endfunction

  // one sys_clk step; a new ADC sample is presented before every sample event
  task automatic tick();
    @(negedge sys_clk);
    if (ad_clk) begin
      ad_data = gen(idx);
      ad_otr  = (idx == otr_idx);
      idx++;
    end
  endtask

  task automatic do_arm();
    tick();
    while (ad_clk) tick();
    arm = 1'b1;
    idx = 0;
    tick();
    arm = 1'b0;
    chk("busy_after_arm", busy, 1);
    chk("done_after_arm", done, 0);
    chk("otr_after_arm", otr_flag, 0);
  endtask

  task automatic wait_done(input string tag, input int last_exp);
    int n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    if (last_exp >= 0) chk({tag, "_last_kept"}, idx - 2, last_exp);
  endtask

  task automatic read_window(input string tag, input int tst, input int base);
    logic [7:0] e;
    for (int i = 0; i <= 256; i++) begin
      tick();
      if (rdq.size() > 0) begin
        e = rdq.pop_front();
        chk(tag, rd_data, e);
      end
      if (i < 256) begin
        rd_addr = 8'(base + i);
        rdq.push_back(exp_val(tst, (base + i) & 255));
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0; ad_data = '0; ad_otr = 1'b0; arm = 1'b0; force_trig = 1'b0;
    trig_level = 8'd100; trig_edge = 1'b0; decim = 8'd0; rd_addr = '0;
    tick(); tick();
    chk("rst_ad_clk", ad_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_pos", trig_pos, 0);
    chk("rst_otr", otr_flag, 0);
    chk("rst_rd_data", rd_data, 0);
    sys_rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk("idle_ad_clk", ad_clk, n % 2);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_trig_pos", trig_pos, 0);
    end

    // rising ramp, trigger at sample 100
    mode = 0;
    do_arm();
    wait_done("ramp_up", 100 + 223);
    chk("ramp_up_trig_pos", trig_pos, 100);
    chk("ramp_up_otr", otr_flag, 0);
    read_window("ramp_up_rd", 1, 100 - 32);

    // falling ramp, first sample below 128 is 127 at sample 128
    mode = 1; trig_level = 8'd128; trig_edge = 1'b1;
    do_arm();
    wait_done("ramp_dn", 128 + 223);
    chk("ramp_dn_trig_pos", trig_pos, 128);
    read_window("ramp_dn_rd", 2, 128 - 32);

    // decimate by 4, out-of-range on a dropped sample
    mode = 0; trig_level = 8'd200; trig_edge = 1'b0; decim = 8'd3; otr_idx = 9;
    do_arm();
    wait_done("dec_drop", -1);
    chk("dec_drop_trig_pos", trig_pos, 50);
    chk("dec_drop_otr", otr_flag, 0);
    read_window("dec_drop_rd", 4, 50 - 32);

    // out-of-range on a kept sample, arm pulse during POST is ignored
    otr_idx = 12;
    do_arm();
    repeat (600) tick();
    chk("post_busy", busy, 1);
    chk("post_otr", otr_flag, 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_done("dec_keep", -1);
    chk("dec_keep_trig_pos", trig_pos, 50);
    chk("dec_keep_otr", otr_flag, 1);
    read_window("dec_keep_rd", 4, 50 - 32);

    // constant input never crosses the level; force a trigger mid-ARMED
    mode = 2; decim = 8'd0; otr_idx = -1; trig_level = 8'd100;
    do_arm();
    repeat (120) tick();
    tick();
    while (!ad_clk) tick();
    force_trig = 1'b1;
    ftk = idx - 1;
    tick();
    force_trig = 1'b0;
    wait_done("force", ftk + 223);
    chk("force_trig_pos", trig_pos, ftk & 255);
    read_window("force_rd", 3, 0);

    // reset in the middle of POST
    mode = 0; otr_idx = 5;
    do_arm();
    repeat (300) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_otr", otr_flag, 1);
    chk("pre_rst_trig_pos", trig_pos, 100);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_ad_clk", ad_clk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_trig_pos", trig_pos, 0);
    chk("abort_otr", otr_flag, 0);
    chk("abort_rd_data", rd_data, 0);
    repeat (3) tick();
    sys_rst_n = 1'b1;
    otr_idx = -1;
    repeat (4) tick();
    do_arm();
    wait_done("rearm", 100 + 223);
    chk("rearm_trig_pos", trig_pos, 100);
    read_window("rearm_rd", 1, 100 - 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
